// File: rtl/traffic_pkg.sv
// Definitions shared between the traffic light controller and its sensor
// front end: light encoding and the debounce state encoding.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_RISE_CHK,
    DB_HIGH,
    DB_FALL_CHK
  } db_state_e;

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser plus debounce FSM for the vehicle loop sensor.
// Emits a single-cycle arrive pulse per debounced rising level.
module sensor_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic arrive
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          s_sync_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the sync chain a chain.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1_q  <= 1'b0;
      s_sync_q <= 1'b0;
      state_q  <= DB_LOW;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      s_sync_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arrive  = 1'b0;
    case (state_q)
      DB_LOW: begin
        if (s_sync_q) begin
          state_d = DB_RISE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      DB_RISE_CHK: begin
        if (!s_sync_q) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
          arrive  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_HIGH: begin
        if (!s_sync_q) begin
          state_d = DB_FALL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      DB_FALL_CHK: begin
        // A bounce back high while leaving is the same car, not a new one.
        if (s_sync_q) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_LOW;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Country-road car queue: counts debounced arrivals, retires cars during
// CR green, and drives the registered car-waiting request X.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SERVICE_CYCLES  = 3,
  parameter int MAX_CARS        = 7,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sensor_raw,
  input  logic [1:0]       CR,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow
);

  localparam int SW = $clog2(SERVICE_CYCLES + 1);
  localparam logic [SW-1:0]    SVC_ONE  = SW'(1);
  localparam logic [SW-1:0]    SVC_LAST = SW'(SERVICE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CARS);

  logic             arrive;
  logic             depart;
  logic             green;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             x_q, x_d;
  logic [SW-1:0]    svc_q, svc_d;

  sensor_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .clear (clear),
    .din   (sensor_raw),
    .arrive(arrive)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      x_q     <= 1'b0;
      svc_q   <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      x_q     <= x_d;
      svc_q   <= svc_d;
    end
  end

  always_comb begin
    // The illegal code 3 falls out as not-green here.
    green  = (CR == GREEN);
    depart = green && (count_q != '0) && (svc_q == SVC_LAST);

    // Partial service is dropped whenever the green phase or the queue ends.
    if (!green || (count_q == '0) || depart) svc_d = '0;
    else                                     svc_d = svc_q + SVC_ONE;

    count_d = count_q;
    ovf_d   = ovf_q;
    case ({arrive, depart})
      2'b10: begin
        if (count_q == CNT_MAX) ovf_d   = 1'b1;
        else                    count_d = count_q + CNT_ONE;
      end
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase

    x_d = (count_d != '0);
  end

  assign X         = x_q;
  assign car_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner: a run-length model of the
// sensor/queue behaviour checked every cycle, plus hand-computed checkpoints.
module tb_vehicle_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int SVC  = 3;
  localparam int MAXC = 7;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          sensor_raw = 1'b0;
  logic [1:0]    CR = 2'd0;
  logic          X;
  logic [CW-1:0] car_count;
  logic          overflow;

  int n_chk  = 0;
  int n_fail = 0;

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SERVICE_CYCLES (SVC),
    .MAX_CARS       (MAXC),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .sensor_raw(sensor_raw),
    .CR        (CR),
    .X         (X),
    .car_count (car_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Model: the accepted level flips once the synchronised input has disagreed
  // with it for DEB+1 consecutive cycles; a flip to 1 is one arrival.
  typedef struct packed {
    logic s1;
    logic s2;
    logic level;
    int   run;
    int   svc;
    int   cnt;
    logic ovf;
  } model_t;

  model_t m = '0;

  function automatic model_t next_model(model_t cur, logic sraw, logic [1:0] cr);
    model_t n   = cur;
    logic   arr = 1'b0;
    logic   dep = 1'b0;
    if (cur.s2 != cur.level) begin
      n.run = cur.run + 1;
      if (n.run == DEB + 1) begin
        n.level = cur.s2;
        n.run   = 0;
        arr     = cur.s2;
      end
    end else begin
      n.run = 0;
    end
    if (cr == 2'd2 && cur.cnt > 0) begin
      n.svc = cur.svc + 1;
      if (n.svc == SVC) begin
        dep   = 1'b1;
        n.svc = 0;
      end
    end else begin
      n.svc = 0;
    end
    if (arr && !dep) begin
      if (cur.cnt == MAXC) n.ovf = 1'b1;
      else                 n.cnt = cur.cnt + 1;
    end else if (dep && !arr) begin
      n.cnt = cur.cnt - 1;
    end
    n.s2 = cur.s1;
    n.s1 = sraw;
    return n;
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) m <= '0;
    else        m <= next_model(m, sensor_raw, CR);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_x",     32'(X),         32'(m.cnt != 0));
      check("cmp_count", 32'(car_count), 32'(m.cnt));
      check("cmp_ovf",   32'(overflow),  32'(m.ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    sensor_raw = 1'b1;
    step(10);
    sensor_raw = 1'b0;
    step(10);
  endtask

  initial begin
    CR = 2'd2;
    #2 clear = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 sensor_raw = ~sensor_raw;
    end
    check("rst_x", 32'(X), 0);
    check("rst_count", 32'(car_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    sensor_raw = 1'b0;
    CR = 2'd0;
    step(3);
    clear = 1'b1;
    step(3);
    check("post_rst_count", 32'(car_count), 0);

    // Clean arrival: count moves on the 7th edge after the rise.
    sensor_raw = 1'b1;
    step(6);
    check("pre_arrive_count", 32'(car_count), 0);
    check("pre_arrive_x", 32'(X), 0);
    step(1);
    check("arrive_count", 32'(car_count), 1);
    check("arrive_x", 32'(X), 1);
    step(3);
    sensor_raw = 1'b0;
    step(10);
    check("parked_once", 32'(car_count), 1);

    // Bounce: high runs of 2 cycles never qualify.
    repeat (3) begin
      sensor_raw = 1'b1;
      step(2);
      sensor_raw = 1'b0;
      step(2);
    end
    step(10);
    check("bounce_reject", 32'(car_count), 1);
    pulse();
    check("after_bounce", 32'(car_count), 2);
    pulse();
    check("three_cars", 32'(car_count), 3);

    // Full service: one car every 3 green cycles.
    CR = 2'd2;
    step(3);
    check("svc_1", 32'(car_count), 2);
    step(3);
    check("svc_2", 32'(car_count), 1);
    step(2);
    check("svc_x_hold", 32'(X), 1);
    step(1);
    check("svc_3", 32'(car_count), 0);
    check("svc_x_fall", 32'(X), 0);
    CR = 2'd0;
    step(2);

    // Green interrupted by yellow: partial service is discarded.
    repeat (3) pulse();
    check("refill", 32'(car_count), 3);
    CR = 2'd2;
    step(3);
    check("yel_svc_1", 32'(car_count), 2);
    step(2);
    CR = 2'd1;
    step(3);
    check("yellow_hold", 32'(car_count), 2);
    CR = 2'd2;
    step(2);
    check("timer_restart", 32'(car_count), 2);
    step(1);
    check("restart_svc", 32'(car_count), 1);
    step(3);
    check("drained", 32'(car_count), 0);
    CR = 2'd0;
    step(2);

    // Arrival coinciding with the third service cycle.
    repeat (2) pulse();
    check("sim_pre", 32'(car_count), 2);
    sensor_raw = 1'b1;
    step(4);
    CR = 2'd2;
    step(2);
    check("sim_mid", 32'(car_count), 2);
    step(1);
    check("simultaneous", 32'(car_count), 2);
    CR = 2'd0;
    step(3);
    sensor_raw = 1'b0;
    step(10);
    check("sim_after", 32'(car_count), 2);

    // Saturation from a fresh reset.
    #2 clear = 1'b0;
    #1 check("arst_count", 32'(car_count), 0);
    step(1);
    clear = 1'b1;
    step(2);
    repeat (7) pulse();
    check("sat_count7", 32'(car_count), 7);
    check("sat_ovf0", 32'(overflow), 0);
    pulse();
    check("sat_count8", 32'(car_count), 7);
    check("sat_ovf1", 32'(overflow), 1);
    check("sat_x", 32'(X), 1);

    // Asynchronous reset in the middle of a debounce.
    sensor_raw = 1'b1;
    step(4);
    #2 clear = 1'b0;
    #1;
    check("mid_rst_x", 32'(X), 0);
    check("mid_rst_count", 32'(car_count), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    step(3);
    check("rst_held_count", 32'(car_count), 0);
    clear = 1'b1;
    step(12);
    check("rearrive", 32'(car_count), 1);
    sensor_raw = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
Name: vehicle_sensor_conditioner

Overview:
- Upstream stage of the traffic light controller: turns the raw, asynchronous country-road vehicle loop sensor into the clean car-present request X that the controller consumes.
- Synchronises and debounces the sensor, and counts queued cars as arrivals.
- Retires queued cars while the controller shows country-road green, taking its CR output as feedback.
- Holds X high while any car is queued.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a sensor level change (≥1).
- SERVICE_CYCLES, 3: CR-green cycles needed to retire one queued car (≥1).
- MAX_CARS, 7: saturation value of the queue counter (≥1).
- CNT_W, 3: width of car_count; must satisfy 2^CNT_W > MAX_CARS.

Ports:
- clk, input, 1: system clock, rising edge.
- clear, input, 1: asynchronous, active-low reset.
- sensor_raw, input, 1: raw loop sensor, asynchronous to clk; 1 = vehicle over loop.
- CR, input, 2: country-road light from the controller (RED=0, YELLOW=1, GREEN=2).
- X, output, 1: car-waiting request to the controller.
- car_count, output, CNT_W: number of queued cars.
- overflow, output, 1: sticky flag, set when an arrival occurs at saturation.

Behaviour:
- Reset (clear=0, asynchronous):
  - Outputs: X=0, car_count=0, overflow=0.
  - Internal: synchroniser flops=0, debounce FSM=LOW, debounce counter=0, service counter=0.
  - Registers hold reset values while clear=0. Normal operation starts on the first rising clk edge after clear deasserts.
- Synchroniser: two-flop chain on sensor_raw; s_sync is the second flop. This adds 2 cycles of latency.
- Debounce FSM, states LOW, RISE_CHK, HIGH, FALL_CHK:
  - LOW: if s_sync=1, go to RISE_CHK with cnt=1.
  - RISE_CHK:
    - s_sync=0: return to LOW.
    - s_sync=1 and cnt=DEBOUNCE_CYCLES: go to HIGH and emit a one-cycle arrive pulse.
    - Otherwise: cnt++.
  - HIGH: if s_sync=0, go to FALL_CHK with cnt=1.
  - FALL_CHK:
    - s_sync=1: return to HIGH with no new arrival.
    - s_sync=0 and cnt=DEBOUNCE_CYCLES: go to LOW.
    - Otherwise: cnt++.
  - Net effect: one arrival per debounced rising level. A sustained high (parked car) counts once.
  - Arrival latency from a sensor_raw rise held stable: 2 sync cycles + DEBOUNCE_CYCLES; car_count updates on the following edge.
- Service timer:
  - Counts cycles while CR==GREEN and car_count>0.
  - On reaching SERVICE_CYCLES, emits a one-cycle depart pulse and resets to 0.
  - Resets to 0 whenever CR!=GREEN or car_count==0. Partial service does not carry across green phases.
- Queue counter update, per cycle:
  - arrive only: increment, saturating at MAX_CARS. An arrive at MAX_CARS leaves the count unchanged and sets overflow.
  - depart only: decrement (depart never fires at 0).
  - arrive and depart in the same cycle: count unchanged, overflow unchanged.
- overflow: cleared only by reset.
- X: registered output, X = (car_count_next != 0). X therefore rises on the same edge that car_count leaves 0, and falls on the edge that car_count reaches 0.
- CR values 3 (illegal) are treated as not green.
- Reset mid-operation (clear low at any time): all state is discarded immediately; no pending arrival or depart survives.

Decomposition:
- Shared package traffic_pkg:
  - Light encoding constants RED=2'd0, YELLOW=2'd1, GREEN=2'd2, shared with the controller.
  - Debounce state encoding.
- One natural sub-module: sensor_debouncer.
  - Contains the synchroniser and debounce FSM.
  - Ports: clk, clear, din, arrive; parameter DEBOUNCE_CYCLES.
  - Instantiated once.
- Queue counter and service timer stay in the top module.

Test Plan:
- Reset: hold clear=0 with sensor_raw toggling and CR=GREEN -> X=0, car_count=0, overflow=0 throughout; first output activity only after clear rises.
- Clean arrival: after reset, CR=RED, sensor_raw high for 10 cycles -> arrive 6 cycles after the rise; car_count=1 and X=1 one edge later; no second count while the sensor stays high.
- Bounce rejection: sensor_raw 1,0,1,0 toggling every 2 cycles for 12 cycles, then low -> car_count stays 0, X stays 0. A later clean 10-cycle pulse -> car_count=1.
- Service: car_count=3, then CR=GREEN for 9 cycles -> car_count 2,1,0 at cycles 3,6,9; X falls on the edge car_count hits 0. If CR drops to YELLOW at cycle 5 -> car_count=2, and the timer restarts from 0 on the next green.
- Simultaneous events: car_count=2, CR=GREEN, arrival pulse timed to coincide with the third service cycle -> car_count remains 2.
- Saturation and mid-operation reset: 8 clean arrivals with CR=RED -> car_count=7, overflow=1 after the eighth. Then assert clear mid-debounce -> X=0, car_count=0, overflow=0 immediately (asynchronously).
